io_in_filter: RTL

IO_IN_FILTER -- requirements
Module: io_in_filter

---
 rtl/io_pkg.sv | 17 +
 rtl/io_in_filter_ch.sv | 76 +++++++
 rtl/io_in_filter.sv | 53 +++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared defaults and types for the io_in_filter pad-input conditioning block.
package io_pkg;

  localparam int unsigned MAX_WIDTH       = 32;
  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_FILT_W      = 4;

  localparam logic [MAX_WIDTH-1:0] DEF_RESET_VAL = '0;

  // Next-cycle edge events of one channel, consumed by the top to build any_change.
  typedef struct packed {
    logic rise;
    logic fall;
  } edge_evt_t;

endpackage

// File: rtl/io_in_filter_ch.sv
// One pad channel: synchroniser chain, stable-cycle glitch filter, filtered level
// and registered rise/fall pulses.
module io_in_filter_ch
  import io_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned FILT_W      = DEF_FILT_W,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pad,
  input  logic [FILT_W-1:0] filt_len,
  input  logic              bypass,
  output logic              y,
  output logic              rise,
  output logic              fall,
  output edge_evt_t         evt_c
);

  (* async_reg = "true", dont_touch = "true" *) logic [SYNC_STAGES-1:0] sync_q;

  logic              s;
  logic [FILT_W-1:0] cnt_q;
  logic [FILT_W-1:0] cnt_d;
  logic              y_d;
  logic              rise_d;
  logic              fall_d;

  // Metastability chain; s is the first stage safe to use in logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Filter decision: commit once s has differed from y for more than filt_len cycles.
  always_comb begin
    cnt_d = cnt_q;
    y_d   = y;
    if (bypass) begin
      y_d   = s;
      cnt_d = '0;
    end else if (s == y) begin
      cnt_d = '0;
    end else if (cnt_q >= filt_len) begin
      y_d   = s;
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + FILT_W'(1);
    end
    rise_d = y_d & ~y;
    fall_d = ~y_d & y;
  end

  assign evt_c = '{rise: rise_d, fall: fall_d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      y     <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      y     <= y_d;
      rise  <= rise_d;
      fall  <= fall_d;
    end
  end

endmodule

// File: rtl/io_in_filter.sv
// Multi-channel pad input conditioner: WIDTH independent filtered channels plus a
// registered summary flag that pulses alongside any channel edge.
module io_in_filter
  import io_pkg::*;
#(
  parameter int unsigned      WIDTH       = DEF_WIDTH,
  parameter int unsigned      SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned      FILT_W      = DEF_FILT_W,
  parameter logic [WIDTH-1:0] RESET_VAL   = WIDTH'(DEF_RESET_VAL)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  pad_in,
  input  logic [FILT_W-1:0] filt_len,
  input  logic [WIDTH-1:0]  bypass,
  output logic [WIDTH-1:0]  y,
  output logic [WIDTH-1:0]  rise,
  output logic [WIDTH-1:0]  fall,
  output logic              any_change
);

  edge_evt_t [WIDTH-1:0] evt_c;
  logic      [WIDTH-1:0] edge_c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    io_in_filter_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W),
      .RESET_VAL   (RESET_VAL[i])
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .pad      (pad_in[i]),
      .filt_len (filt_len),
      .bypass   (bypass[i]),
      .y        (y[i]),
      .rise     (rise[i]),
      .fall     (fall[i]),
      .evt_c    (evt_c[i])
    );
    assign edge_c[i] = evt_c[i].rise | evt_c[i].fall;
  end

  // Built from next-cycle events so it lands in the same cycle as rise/fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_change <= 1'b0;
    end else begin
      any_change <= |edge_c;
    end
  end

endmodule
